// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock, LSB first
// Ports: clk/rst_n (async active-low); start/a/b/bin load operands when idle or done;
// busy high while bits are processed; done pulses one cycle with diff/borrow/ovf valid,
// which then hold until the next result or reset.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, work;
  logic [5:0] cnt;
  logic br, ai, bi, d, br_nxt, last, load;
  always_comb begin
    ai = sa[0];
    bi = sb[0];
    d = ai ^ bi ^ br;
    br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
    last = cnt == 6'(WIDTH - 1);
    load = start && state != RUN;
    state_nxt = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  // Results accumulate in work so diff only changes on entry to DONE; on the last bit
  // ai/bi are the operand sign bits, which is all ovf needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      work <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sa <= a;
        sb <= b;
        br <= bin;
        cnt <= '0;
      end else if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= br_nxt;
        cnt <= cnt + 6'd1;
        work <= (work >> 1) | (WIDTH'(d) << (WIDTH - 1));
        if (last) begin
          diff <= (work >> 1) | (WIDTH'(d) << (WIDTH - 1));
          borrow <= br_nxt;
          ovf <= (ai ^ bi) & (d ^ ai);
        end
      end
    end
  end
endmodule
